cb_seq: RTL
===========

CB_SEQ -- requirements
Module: cb_seq

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: nreset  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start in 1 (accept request), opcode in 8 (CB-prefixed opcode byte), busy out 1, done out 1 (one-cycle completion pulse).
REQ-004 SHALL have ports: reg_sel out 3, reg_rdata in 8, reg_we out 1, reg_wdata out 8 (register file access).
REQ-005 SHALL have ports: mem_rd out 1, mem_wr out 1, mem_wdata out 8, mem_rdata in 8, mem_ack in 1 (operand (HL) access).
REQ-006 SHALL have ports: alu_op out 2, alu_bit out 3, alu_a out 8, alu_res in 8, alu_zf in 1 (external combinational ALU).
REQ-007 SHALL have ports: flag_z out 1, flag_we out 1 (Z flag update).

Function
REQ-008 SHALL decode the latched opcode as: group = op[7:6] (00 rot/shift, 01 BIT, 10 RES, 11 SET), bit/sub = op[5:3], operand index = op[2:0]; index 6 = memory operand.
REQ-009 SHALL drive alu_op = group, alu_bit = op[5:3], alu_a = latched operand whenever busy.
REQ-010 SHALL use FSM states IDLE, RD_REG, MEM_RD, EXEC, MEM_WR, DONE.
REQ-011 IDLE: start=1 latches opcode, busy=1 next cycle; next state MEM_RD if index 6 else RD_REG.
REQ-012 RD_REG: reg_sel = index; reg_rdata latched as operand; next EXEC.
REQ-013 MEM_RD: mem_rd held 1 until the cycle mem_ack=1; mem_rdata latched that cycle; next EXEC.
REQ-014 EXEC (exactly one cycle): group 00/01 -> flag_we=1, flag_z=alu_zf; group 00/10/11 with register operand -> reg_we=1, reg_sel=index, reg_wdata=alu_res; BIT never writes back.
REQ-015 EXEC next state: memory operand and group != 01 -> MEM_WR with alu_res captured into mem_wdata; otherwise DONE.
REQ-016 MEM_WR: mem_wr held 1, mem_wdata stable, until cycle mem_ack=1; next DONE.
REQ-017 DONE: done=1 for one cycle, busy=0 in same cycle, next IDLE; start is accepted in DONE? no -- only in IDLE.
REQ-018 Register-path latency SHALL be fixed: start at cycle N -> RD_REG N+1, EXEC N+2, done at N+3.
REQ-019 start while busy or in DONE SHALL be ignored, no queuing.
REQ-020 mem_ack outside MEM_RD/MEM_WR SHALL be ignored; mem_rd and mem_wr SHALL never be 1 simultaneously.
REQ-021 reg_we, flag_we, mem_rd, mem_wr SHALL be 0 in every state not listed above as asserting them.

Reset
REQ-022 nreset=0 SHALL immediately force IDLE, busy=0, done=0, reg_we=0, flag_we=0, mem_rd=0, mem_wr=0, flag_z=0, latched opcode/operand=0, regardless of clk.
REQ-023 Reset mid-transaction SHALL abandon it without writeback; first start after release is processed normally.

Configuration
REQ-024 Macro CB_SEQ_MEM_EN: defined -> index 6 uses MEM_RD/MEM_WR path as above.
REQ-025 CB_SEQ_MEM_EN undefined -> MEM_RD/MEM_WR states absent, mem_rd/mem_wr/mem_wdata tied 0, index 6 handled as register via RD_REG path.

Verification
REQ-026 reg[3]=0xf7, start opcode 0x5B (BIT 3,E) -> EXEC flag_we=1 flag_z=1, reg_we never 1, done at N+3.
REQ-027 reg[0]=0x00, opcode 0xF8 (SET 7,B) -> EXEC reg_we=1 reg_sel=0 reg_wdata=0x80, flag_we=0, done at N+3.
REQ-028 (CB_SEQ_MEM_EN) opcode 0x86 (RES 0,(HL)), mem_ack after 2 cycles, mem_rdata=0xff -> mem_wr with mem_wdata=0xfe until ack, then done pulse.
REQ-029 (CB_SEQ_MEM_EN) opcode 0x7E (BIT 7,(HL)), mem_rdata=0xa5 -> flag_z=0, no mem_wr, done after EXEC.
REQ-030 start pulses while busy and stray mem_ack in IDLE -> ignored; only first opcode executes.
REQ-031 nreset low during MEM_RD -> mem_rd=0 and busy=0 immediately, no reg_we/mem_wr afterwards.

Source files
------------

// File: rtl/cb_seq_if.sv
// cb_seq_if: request, register-file, (HL) memory, ALU and flag signals
// of the CB-prefix sequencer. slave = sequencer side, master = environment.
interface cb_seq_if;
   logic       start;
   logic [7:0] opcode;
   logic       busy;
   logic       done;
   logic [2:0] reg_sel;
   logic [7:0] reg_rdata;
   logic       reg_we;
   logic [7:0] reg_wdata;
   logic       mem_rd;
   logic       mem_wr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;
   logic [1:0] alu_op;
   logic [2:0] alu_bit;
   logic [7:0] alu_a;
   logic [7:0] alu_res;
   logic       alu_zf;
   logic       flag_z;
   logic       flag_we;

   modport slave (
      input  start, opcode, reg_rdata, mem_rdata,
      input  mem_ack, alu_res, alu_zf,
      output busy, done, reg_sel, reg_we, reg_wdata,
      output mem_rd, mem_wr, mem_wdata,
      output alu_op, alu_bit, alu_a, flag_z, flag_we
   );

   modport master (
      output start, opcode, reg_rdata, mem_rdata,
      output mem_ack, alu_res, alu_zf,
      input  busy, done, reg_sel, reg_we, reg_wdata,
      input  mem_rd, mem_wr, mem_wdata,
      input  alu_op, alu_bit, alu_a, flag_z, flag_we
   );
endinterface

// File: rtl/cb_seq.sv
// cb_seq: sequences one CB-prefixed op (rot/shift, BIT, RES, SET)
// through an external combinational ALU.
// Ports: clk, nreset (async, active low), bus (cb_seq_if.slave):
//   start/opcode/busy/done request side, reg_* register file,
//   mem_* (HL) operand, alu_* ALU, flag_z/flag_we Z flag update.
// Macro CB_SEQ_MEM_EN: when defined, operand index 6 goes through
//   MEM_RD/MEM_WR; otherwise it is a plain register and mem_* are 0.
module cb_seq (
   input  logic    clk,
   input  logic    nreset,
   cb_seq_if.slave bus
);
   localparam logic [1:0] GRP_ROT = 2'b00;
   localparam logic [1:0] GRP_BIT = 2'b01;

`ifdef CB_SEQ_MEM_EN
   typedef enum logic [2:0] {
      IDLE, RD_REG, MEM_RD, EXEC, MEM_WR, DONE
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE, RD_REG, EXEC, DONE
   } state_t;
`endif

   state_t     state_q, state_d;
   logic [7:0] op_q, op_d;
   logic [7:0] opnd_q, opnd_d;
   logic [1:0] grp;
   logic [2:0] idx;
   logic       busy, done;
   logic       reg_we, flag_we, flag_z;
   logic [2:0] reg_sel;
   logic [7:0] reg_wdata;
`ifdef CB_SEQ_MEM_EN
   logic       is_mem;
   logic       mem_rd, mem_wr;
   logic [7:0] mem_wdata_q, mem_wdata_d;
`endif

   assign grp = op_q[7:6];
   assign idx = op_q[2:0];
`ifdef CB_SEQ_MEM_EN
   assign is_mem = (idx == 3'd6);
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         op_q    <= '0;
         opnd_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
      end
   end

`ifdef CB_SEQ_MEM_EN
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         mem_wdata_q <= '0;
      end else begin
         mem_wdata_q <= mem_wdata_d;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      opnd_d    = opnd_q;
      busy      = 1'b0;
      done      = 1'b0;
      reg_we    = 1'b0;
      reg_sel   = 3'd0;
      reg_wdata = 8'd0;
      flag_we   = 1'b0;
      flag_z    = 1'b0;
`ifdef CB_SEQ_MEM_EN
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_wdata_d = mem_wdata_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d    = bus.opcode;
               state_d = RD_REG;
`ifdef CB_SEQ_MEM_EN
               if (bus.opcode[2:0] == 3'd6) begin
                  state_d = MEM_RD;
               end
`endif
            end
         end
         RD_REG: begin
            busy    = 1'b1;
            reg_sel = idx;
            opnd_d  = bus.reg_rdata;
            state_d = EXEC;
         end
`ifdef CB_SEQ_MEM_EN
         MEM_RD: begin
            busy   = 1'b1;
            mem_rd = 1'b1;
            if (bus.mem_ack) begin
               opnd_d  = bus.mem_rdata;
               state_d = EXEC;
            end
         end
`endif
         EXEC: begin
            busy    = 1'b1;
            reg_sel = idx;
            state_d = DONE;
            if (grp == GRP_ROT || grp == GRP_BIT) begin
               flag_we = 1'b1;
               flag_z  = bus.alu_zf;
            end
            // BIT only tests; everything else writes its result back
            if (grp != GRP_BIT) begin
`ifdef CB_SEQ_MEM_EN
               if (is_mem) begin
                  mem_wdata_d = bus.alu_res;
                  state_d     = MEM_WR;
               end else begin
                  reg_we    = 1'b1;
                  reg_wdata = bus.alu_res;
               end
`else
               reg_we    = 1'b1;
               reg_wdata = bus.alu_res;
`endif
            end
         end
`ifdef CB_SEQ_MEM_EN
         MEM_WR: begin
            busy   = 1'b1;
            mem_wr = 1'b1;
            if (bus.mem_ack) begin
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.reg_sel   = reg_sel;
   assign bus.reg_we    = reg_we;
   assign bus.reg_wdata = reg_wdata;
   assign bus.flag_we   = flag_we;
   assign bus.flag_z    = flag_z;
   assign bus.alu_op    = busy ? grp : 2'b00;
   assign bus.alu_bit   = busy ? op_q[5:3] : 3'd0;
   assign bus.alu_a     = busy ? opnd_q : 8'd0;

`ifdef CB_SEQ_MEM_EN
   assign bus.mem_rd    = mem_rd;
   assign bus.mem_wr    = mem_wr;
   assign bus.mem_wdata = mem_wdata_q;
`else
   logic unused_mem;
   assign unused_mem    = ^{bus.mem_rdata, bus.mem_ack};
   assign bus.mem_rd    = 1'b0;
   assign bus.mem_wr    = 1'b0;
   assign bus.mem_wdata = 8'd0;
`endif
endmodule
